// File: rtl/mmu_result_drain_pkg.sv
// mmu_result_drain_pkg: shared defaults and drain FSM state type
package mmu_result_drain_pkg;
  localparam int ACC_WIDTH_DEF = 32;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} drain_state_t;
endpackage

// File: rtl/mmu_result_drain_fifo.sv
// mmu_result_drain_fifo: synchronous row FIFO with simultaneous push/pop
module mmu_result_drain_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/mmu_result_drain.sv
// mmu_result_drain: deskews the systolic result bus into rows and buffers them for a consumer
module mmu_result_drain
  import mmu_result_drain_pkg::*;
#(
  parameter int SIZE       = 4,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      control,
  input  logic                      in_valid,
  input  logic [SIZE*ACC_WIDTH-1:0] acc_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SIZE*ACC_WIDTH-1:0] out_row,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      busy,
  output logic                      overflow,
  output logic [IDX_W-1:0]          drop_count,
  output logic                      proto_err
);
  localparam int TAG_LEN = PIPE_LAT + SIZE - 1;
  localparam int RW      = SIZE * ACC_WIDTH;
  logic [TAG_LEN-1:0] tag;
  logic [RW-1:0] row_in, row_out;
  logic [IDX_W-1:0] row_idx, idx_out;
  logic push, pop, full, empty;
  drain_state_t state;
  assign push      = tag[TAG_LEN-1];
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign out_row   = out_valid ? row_out : '0;
  assign out_idx   = out_valid ? idx_out : '0;
  assign busy      = |tag | ~empty;
  for (genvar j = 0; j < SIZE; j++) begin : g_col
    if (j == SIZE - 1) begin : g_direct
      assign row_in[ACC_WIDTH*(j+1)-1 -: ACC_WIDTH] = acc_out[ACC_WIDTH*(j+1)-1 -: ACC_WIDTH];
    end else begin : g_dl
      logic [ACC_WIDTH-1:0] dl [SIZE-1-j];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < SIZE - 1 - j; i++) dl[i] <= '0;
        end else begin
          dl[0] <= acc_out[ACC_WIDTH*(j+1)-1 -: ACC_WIDTH];
          for (int i = 1; i < SIZE - 1 - j; i++) dl[i] <= dl[i-1];
        end
      end
      assign row_in[ACC_WIDTH*(j+1)-1 -: ACC_WIDTH] = dl[SIZE-2-j];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tag        <= '0;
      row_idx    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      tag       <= {tag[TAG_LEN-2:0], in_valid & ~control};
      proto_err <= proto_err | (in_valid & control);
      row_idx   <= (state == LOAD && !control) ? '0 : row_idx + IDX_W'(push);
      if (push & full & ~pop) begin
        overflow   <= 1'b1;
        drop_count <= &drop_count ? drop_count : drop_count + 1'b1;
      end
      state <= state == IDLE ? (control ? LOAD : in_valid ? STREAM : IDLE) :
               state == LOAD ? (control ? LOAD : STREAM) :
               control ? LOAD : (~|tag & ~in_valid) ? IDLE : STREAM;
    end
  end
  mmu_result_drain_fifo #(.W(IDX_W + RW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({row_idx, row_in}),
    .dout  ({idx_out, row_out}),
    .full  (full),
    .empty (empty)
  );
endmodule
